// File: rtl/weight_write_ctrl.sv
// weight_write_ctrl
//   Write-side controller for the weight RAM image read by the weight store.
//   A start request selects a layer (cs) and phase. The block then accepts
//   BEATS beats of 9 words over a valid/ready stream and writes them to
//   consecutive RAM addresses starting at cs_offset + phase*PHASE_STRIDE.
//   This is the same address map the reader uses.
//
// Ports
//   clk, rst_n         clock (posedge) / asynchronous active-low reset
//   start, cs, phase   block request; cs and phase are sampled only when start is taken
//   in_valid, in_ready input beat handshake; in_data carries word 0 in the LSBs
//   we, waddr, wdata   registered RAM write port (one cycle after beat accept)
//   busy               a block write is in progress
//   done               one-cycle pulse when the block is complete
//   err                one-cycle pulse when start is rejected for an invalid cs
//
// State  | meaning
// IDLE   | waiting for start
// WRITE  | accepting beats; in_ready high
// DONE   | last write presented on the RAM port; done pulses on the next cycle

`ifndef DATA_LEN
`define DATA_LEN 8
`endif
`ifndef LAYER0
`define LAYER0 4'd0
`endif
`ifndef LAYER1
`define LAYER1 4'd1
`endif
`ifndef LAYER2
`define LAYER2 4'd2
`endif
`ifndef LAYER3
`define LAYER3 4'd3
`endif
`ifndef AFFINE
`define AFFINE 4'd4
`endif

module weight_write_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int BEATS        = 4,
    parameter int LAYER_STRIDE = 32,
    parameter int PHASE_STRIDE = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [3:0]               cs,
    input  logic [2:0]               phase,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [9*`DATA_LEN-1:0]   in_data,
    output logic                     we,
    output logic [ADDR_W-1:0]        waddr,
    output logic [9*`DATA_LEN-1:0]   wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] cs_offset;
    logic [ADDR_W-1:0] phase_offset;
    logic              cs_valid;
    logic              accept;
    logic              last_beat;
    logic              start_ok;

    always_comb begin
        cs_valid  = 1'b1;
        cs_offset = '0;
        case (cs)
            `LAYER0: cs_offset = ADDR_W'(0 * LAYER_STRIDE);
            `LAYER1: cs_offset = ADDR_W'(1 * LAYER_STRIDE);
            `LAYER2: cs_offset = ADDR_W'(2 * LAYER_STRIDE);
            `LAYER3: cs_offset = ADDR_W'(3 * LAYER_STRIDE);
            `AFFINE: cs_offset = ADDR_W'(4 * LAYER_STRIDE);
            default: cs_valid  = 1'b0;
        endcase
    end

    assign phase_offset = ADDR_W'(phase) * ADDR_W'(PHASE_STRIDE);

    assign in_ready  = (state == ST_WRITE);
    assign busy      = (state != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == CNT_W'(BEATS - 1));
    assign start_ok  = (state == ST_IDLE) && start && cs_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_WRITE;
            ST_WRITE: if (accept && last_beat) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            base  <= '0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            we    <= accept;
            done  <= (state == ST_DONE);
            err   <= (state == ST_IDLE) && start && !cs_valid;
            if (start_ok) begin
                base <= cs_offset + phase_offset;
                cnt  <= '0;
            end
            // waddr/wdata only move on an accepted beat so they hold between writes
            if (accept) begin
                waddr <= base + ADDR_W'(cnt);
                wdata <= in_data;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_weight_write_ctrl.sv
`ifndef DATA_LEN
`define DATA_LEN 8
`endif
`ifndef LAYER0
`define LAYER0 4'd0
`endif
`ifndef LAYER1
`define LAYER1 4'd1
`endif
`ifndef LAYER2
`define LAYER2 4'd2
`endif
`ifndef LAYER3
`define LAYER3 4'd3
`endif
`ifndef AFFINE
`define AFFINE 4'd4
`endif

module tb_weight_write_ctrl;

    localparam int DW    = 9 * `DATA_LEN;
    localparam int BEATS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    cs = 4'd0;
    logic [2:0]    phase = 3'd0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          we;
    logic [7:0]    waddr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic          err;

    weight_write_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cs       (cs),
        .phase    (phase),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a block is "open" while beats are still owed, and has a
    // one-cycle "tail" after the last beat during which the final write shows.
    bit            m_open, m_tail, m_idle;
    int            m_cnt, m_base;
    bit            exp_we, exp_done, exp_err;
    int            exp_waddr;
    logic [DW-1:0] exp_wdata;

    int            wlog[$];
    logic [DW-1:0] dlog[$];
    int            done_cnt, err_cnt;

    function automatic int cs_off(input logic [3:0] c);
        case (c)
            `LAYER0: return 0;
            `LAYER1: return 32;
            `LAYER2: return 64;
            `LAYER3: return 96;
            `AFFINE: return 128;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_open = 0; m_tail = 0; m_cnt = 0; m_base = 0;
        exp_we = 0; exp_done = 0; exp_err = 0;
        exp_waddr = 0; exp_wdata = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_idle   = !m_open && !m_tail;
                exp_we   = 0;
                exp_done = 0;
                exp_err  = 0;
                if (m_tail) begin
                    exp_done = 1;
                    m_tail   = 0;
                end
                if (m_open && in_valid) begin
                    exp_we    = 1;
                    exp_waddr = m_base + m_cnt;
                    exp_wdata = in_data;
                    m_cnt++;
                    if (m_cnt == BEATS) begin
                        m_open = 0;
                        m_tail = 1;
                    end
                end
                if (m_idle && start) begin
                    if (cs_off(cs) >= 0) begin
                        m_open = 1;
                        m_cnt  = 0;
                        m_base = cs_off(cs) + int'(phase) * 4;
                    end else begin
                        exp_err = 1;
                    end
                end
            end
            #1;
            if (rst_n) begin
                check("we", we, exp_we);
                check("waddr", waddr, exp_waddr);
                check("wdata", wdata, exp_wdata);
                check("in_ready", in_ready, m_open);
                check("busy", busy, m_open || m_tail);
                check("done", done, exp_done);
                check("err", err, exp_err);
                if (we) begin
                    wlog.push_back(int'(waddr));
                    dlog.push_back(wdata);
                end
                if (done) done_cnt++;
                if (err) err_cnt++;
            end
        end
    end

    task automatic cyc(input logic s, input logic [3:0] c, input logic [2:0] p,
                       input logic v, input logic [DW-1:0] d);
        @(negedge clk);
        start    = s;
        cs       = c;
        phase    = p;
        in_valid = v;
        in_data  = d;
    endtask

    function automatic logic [DW-1:0] rdata();
        return DW'({$urandom, $urandom, $urandom});
    endfunction

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 4'd0, 3'd0, 0, rdata());
    endtask

    task automatic clear_logs();
        wlog.delete();
        dlog.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic check_addrs(input string name, input int first, input int n);
        check({name, "_count"}, wlog.size(), n);
        for (int i = 0; i < n && i < wlog.size(); i++)
            check({name, "_addr"}, wlog[i], first + i);
    endtask

    logic [DW-1:0] dv[4];
    logic [DW-1:0] r;
    int            vpat[7];

    initial begin
        clear_logs();
        @(negedge clk);
        check("rst_we", we, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_waddr", waddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_n(2);

        // LAYER2 phase 5, back-to-back beats
        clear_logs();
        for (int k = 0; k < 4; k++) dv[k] = rdata();
        cyc(1, `LAYER2, 3'd5, 0, '0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, `LAYER2, 3'd5, 1, dv[k]);
            if (k == 0) begin
                check("t1_busy_after_start", busy, 1);
                check("t1_ready_after_start", in_ready, 1);
            end
        end
        idle_n(4);
        check_addrs("t1", 84, 4);
        for (int k = 0; k < 4 && k < dlog.size(); k++) check("t1_data", dlog[k], dv[k]);
        check("t1_done_cnt", done_cnt, 1);

        // AFFINE phase 7, gappy valid
        clear_logs();
        vpat = '{1, 0, 0, 1, 1, 0, 1};
        cyc(1, `AFFINE, 3'd7, 0, '0);
        for (int k = 0; k < 7; k++) cyc(0, `AFFINE, 3'd7, vpat[k][0], rdata());
        idle_n(4);
        check_addrs("t2", 156, 4);
        check("t2_done_cnt", done_cnt, 1);

        // invalid cs
        clear_logs();
        cyc(1, 4'hF, 3'd0, 1, rdata());
        for (int k = 0; k < 4; k++) cyc(0, 4'hF, 3'd0, 1, rdata());
        idle_n(1);
        check("t3_err_cnt", err_cnt, 1);
        check("t3_writes", wlog.size(), 0);

        // async reset mid-block
        clear_logs();
        cyc(1, `LAYER0, 3'd0, 0, '0);
        cyc(0, `LAYER0, 3'd0, 1, rdata());
        cyc(0, `LAYER0, 3'd0, 1, rdata());
        cyc(0, `LAYER0, 3'd0, 0, '0);
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_we", we, 0);
        check("t4_async_waddr", waddr, 0);
        check("t4_async_wdata", wdata, 0);
        check("t4_async_busy", busy, 0);
        check("t4_async_ready", in_ready, 0);
        for (int k = 0; k < 2; k++) cyc(0, `LAYER0, 3'd0, 1, rdata());
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cyc(0, `LAYER0, 3'd0, 1, rdata());
        idle_n(1);
        check_addrs("t4_pre", 0, 2);
        clear_logs();
        cyc(1, `LAYER1, 3'd1, 0, '0);
        for (int k = 0; k < 4; k++) cyc(0, `LAYER1, 3'd1, 1, rdata());
        idle_n(4);
        check_addrs("t4_post", 36, 4);

        // start during a write is ignored
        clear_logs();
        cyc(1, `LAYER3, 3'd2, 0, '0);
        cyc(0, `LAYER3, 3'd2, 1, rdata());
        cyc(1, `LAYER0, 3'd0, 1, rdata());
        cyc(0, `LAYER0, 3'd0, 1, rdata());
        cyc(0, `LAYER0, 3'd0, 1, rdata());
        idle_n(4);
        check_addrs("t5", 104, 4);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_err_cnt", err_cnt, 0);

        // start in the done cycle
        clear_logs();
        cyc(1, `LAYER0, 3'd3, 0, '0);
        for (int k = 0; k < 4; k++) cyc(0, `LAYER0, 3'd3, 1, rdata());
        cyc(0, `LAYER0, 3'd0, 0, '0);
        cyc(1, `LAYER1, 3'd0, 0, '0);
        check("t6_done_here", done, 1);
        for (int k = 0; k < 4; k++) cyc(0, `LAYER1, 3'd0, 1, rdata());
        idle_n(4);
        check("t6_count", wlog.size(), 8);
        for (int i = 0; i < 4 && i + 4 < wlog.size(); i++) begin
            check("t6_first_addr", wlog[i], 12 + i);
            check("t6_second_addr", wlog[i + 4], 32 + i);
        end
        check("t6_done_cnt", done_cnt, 2);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r = rdata();
            cyc(($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15)),
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 9) < 6),
                r);
            if (n == 1500) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        idle_n(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
